// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the register-file write port.
// A has priority; B is forced through after MAX_WAIT refusals. Option: REGFILE_WB_FWD_EN.
module regfile_wb_arbiter #(
  parameter int N        = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  input  logic [4:0]   a_dest,
  input  logic [N-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [4:0]   b_dest,
  input  logic [N-1:0] b_data,
  output logic         b_ready,
  input  logic         hold,
  output logic         RegWrite,
  output logic [4:0]   wr_dest,
  output logic [N-1:0] wr_data
`ifdef REGFILE_WB_FWD_EN
  ,
  input  logic [4:0]   fwd_src1,
  input  logic [4:0]   fwd_src2,
  output logic         fwd_hit1,
  output logic         fwd_hit2,
  output logic [N-1:0] fwd_data,
  output logic [N-1:0] fwd_data2
`endif
);

  localparam logic [3:0] WMAX = 4'(MAX_WAIT);

  logic [3:0]   wait_q, wait_d;
  logic         we_q, we_d;
  logic [4:0]   dest_q, dest_d;
  logic [N-1:0] data_q, data_d;
  logic         grant_a, grant_b;
  logic         b_force;

  assign b_force = b_valid && (wait_q == WMAX);

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst || hold) begin
      grant_a = 1'b0;
    end else if (b_force) begin
      grant_b = 1'b1;
    end else if (a_valid) begin
      grant_a = 1'b1;
    end else if (b_valid) begin
      grant_b = 1'b1;
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // x0 writes are accepted but never raise the write enable
  always_comb begin
    we_d   = 1'b0;
    dest_d = dest_q;
    data_d = data_q;
    if (grant_a) begin
      we_d   = (a_dest != 5'd0);
      dest_d = a_dest;
      data_d = a_data;
    end else if (grant_b) begin
      we_d   = (b_dest != 5'd0);
      dest_d = b_dest;
      data_d = b_data;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (!b_valid || grant_b) begin
      wait_d = 4'd0;
    end else if (wait_q != WMAX) begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q <= 4'd0;
      we_q   <= 1'b0;
      dest_q <= 5'd0;
      data_q <= '0;
    end else begin
      wait_q <= wait_d;
      we_q   <= we_d;
      dest_q <= dest_d;
      data_q <= data_d;
    end
  end

  assign RegWrite = we_q;
  assign wr_dest  = dest_q;
  assign wr_data  = data_q;

`ifdef REGFILE_WB_FWD_EN
  assign fwd_hit1  = we_q && (dest_q != 5'd0) && (dest_q == fwd_src1);
  assign fwd_hit2  = we_q && (dest_q != 5'd0) && (dest_q == fwd_src2);
  assign fwd_data  = fwd_hit1 ? data_q : '0;
  assign fwd_data2 = fwd_hit2 ? data_q : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (MAX_WAIT=4).
// Inputs change on the falling edge; outputs are sampled 1ns later or 1ns after the rising edge.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_dest;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_dest;
  logic [31:0] b_data;
  logic        b_ready;
  logic        hold;
  logic        RegWrite;
  logic [4:0]  wr_dest;
  logic [31:0] wr_data;
`ifdef REGFILE_WB_FWD_EN
  logic [4:0]  fwd_src1;
  logic [4:0]  fwd_src2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data;
  logic [31:0] fwd_data2;
`endif

  int n_checks;
  int n_fail;

  regfile_wb_arbiter #(.N(32), .MAX_WAIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_dest   (a_dest),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_dest   (b_dest),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .hold     (hold),
    .RegWrite (RegWrite),
    .wr_dest  (wr_dest),
    .wr_data  (wr_data)
`ifdef REGFILE_WB_FWD_EN
    ,
    .fwd_src1 (fwd_src1),
    .fwd_src2 (fwd_src2),
    .fwd_hit1 (fwd_hit1),
    .fwd_hit2 (fwd_hit2),
    .fwd_data (fwd_data),
    .fwd_data2(fwd_data2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic av, input logic [4:0] ad,
                       input logic [31:0] adat, input logic bv,
                       input logic [4:0] bd, input logic [31:0] bdat,
                       input logic h);
    a_valid = av;
    a_dest  = ad;
    a_data  = adat;
    b_valid = bv;
    b_dest  = bd;
    b_data  = bdat;
    hold    = h;
  endtask

  task automatic idle();
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got a=%b b=%b want 0 0", a_ready, b_ready);
    end
    n_checks++;
    if (RegWrite !== 1'b0 || wr_dest !== 5'd0 || wr_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_out: got we=%b d=%0d data=%h want 0 0 0",
               RegWrite, wr_dest, wr_data);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got a=%b b=%b want 1 0", a_ready, b_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (RegWrite !== 1'b1 || wr_dest !== 5'd1 || wr_data !== 32'h11) begin
      n_fail++;
      $display("FAIL reset_first_write: got we=%b d=%0d data=%h want 1 1 11",
               RegWrite, wr_dest, wr_data);
    end
    idle();
  endtask

  task automatic test_a_only();
    @(negedge clk);
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL a_only_ready: got a=%b b=%b want 1 0", a_ready, b_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (RegWrite !== 1'b1 || wr_dest !== 5'd5 || wr_data !== 32'h1234) begin
      n_fail++;
      $display("FAIL a_only_write: got we=%b d=%0d data=%h want 1 5 1234",
               RegWrite, wr_dest, wr_data);
    end
    idle();
    n_checks++;
    if (RegWrite !== 1'b0 || wr_dest !== 5'd5 || wr_data !== 32'h1234) begin
      n_fail++;
      $display("FAIL a_only_after: got we=%b d=%0d data=%h want 0 5 1234",
               RegWrite, wr_dest, wr_data);
    end
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 10; i++) begin
      logic exp_b;
      logic [4:0] exp_d;
      logic [31:0] exp_v;
      exp_b = ((i % 5) == 4);
      exp_d = exp_b ? 5'd4 : 5'd3;
      exp_v = exp_b ? (32'h200 + 32'(i)) : (32'h100 + 32'(i));
      @(negedge clk);
      drive(1'b1, 5'd3, 32'h100 + 32'(i), 1'b1, 5'd4, 32'h200 + 32'(i), 1'b0);
      #1;
      n_checks++;
      if (a_ready !== !exp_b || b_ready !== exp_b) begin
        n_fail++;
        $display("FAIL starve_grant[%0d]: got a=%b b=%b want %b %b",
                 i, a_ready, b_ready, !exp_b, exp_b);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (RegWrite !== 1'b1 || wr_dest !== exp_d || wr_data !== exp_v) begin
        n_fail++;
        $display("FAIL starve_write[%0d]: got we=%b d=%0d data=%h want 1 %0d %h",
                 i, RegWrite, wr_dest, wr_data, exp_d, exp_v);
      end
    end
    idle();
  endtask

  task automatic test_x0();
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    #1;
    n_checks++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_ready: got a=%b b=%b want 0 1", a_ready, b_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_we: got %b want 0", RegWrite);
    end
    idle();
  endtask

  task automatic test_hold();
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0, 1'b1);
      #1;
      n_checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_ready[%0d]: got a=%b b=%b want 0 0",
                 i, a_ready, b_ready);
      end
      if (i == 0) begin
        n_checks++;
        if (RegWrite !== 1'b1 || wr_dest !== 5'd9 || wr_data !== 32'h99) begin
          n_fail++;
          $display("FAIL hold_pending: got we=%b d=%0d data=%h want 1 9 99",
                   RegWrite, wr_dest, wr_data);
        end
      end
      @(posedge clk);
    end
    #1;
    n_checks++;
    if (RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_no_write: got %b want 0", RegWrite);
    end
    // three refusals: A still wins once, then B is forced
    @(negedge clk);
    hold = 1'b0;
    #1;
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release_a: got a=%b b=%b want 1 0", a_ready, b_ready);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_force_b: got a=%b b=%b want 0 1", a_ready, b_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (RegWrite !== 1'b1 || wr_dest !== 5'd13 || wr_data !== 32'hD0) begin
      n_fail++;
      $display("FAIL hold_b_write: got we=%b d=%0d data=%h want 1 13 d0",
               RegWrite, wr_dest, wr_data);
    end
    idle();
  endtask

  task automatic test_same_dest();
    @(negedge clk);
    drive(1'b1, 5'd6, 32'hAAAA, 1'b1, 5'd6, 32'hBBBB, 1'b0);
    @(posedge clk);
    #1;
    n_checks++;
    if (RegWrite !== 1'b1 || wr_dest !== 5'd6 || wr_data !== 32'hAAAA) begin
      n_fail++;
      $display("FAIL same_dest_a: got we=%b d=%0d data=%h want 1 6 aaaa",
               RegWrite, wr_dest, wr_data);
    end
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    n_checks++;
    if (b_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL same_dest_b_ready: got %b want 1", b_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (RegWrite !== 1'b1 || wr_dest !== 5'd6 || wr_data !== 32'hBBBB) begin
      n_fail++;
      $display("FAIL same_dest_b: got we=%b d=%0d data=%h want 1 6 bbbb",
               RegWrite, wr_dest, wr_data);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(1'b1, 5'd10, 32'h5A5A, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (RegWrite !== 1'b0 || wr_dest !== 5'd0 || wr_data !== 32'd0 ||
        a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got we=%b d=%0d data=%h ar=%b want 0 0 0 0",
               RegWrite, wr_dest, wr_data, a_ready);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
  endtask

`ifdef REGFILE_WB_FWD_EN
  task automatic test_fwd();
    @(negedge clk);
    drive(1'b1, 5'd7, 32'hABCD, 1'b0, 5'd0, 32'd0, 1'b0);
    fwd_src1 = 5'd7;
    fwd_src2 = 5'd7;
    #1;
    n_checks++;
    if (fwd_hit1 !== 1'b0 || fwd_data !== 32'd0) begin
      n_fail++;
      $display("FAIL fwd_before: got hit=%b data=%h want 0 0", fwd_hit1, fwd_data);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    fwd_src2 = 5'd0;
    #1;
    n_checks++;
    if (fwd_hit1 !== 1'b1 || fwd_data !== 32'hABCD) begin
      n_fail++;
      $display("FAIL fwd_hit1: got hit=%b data=%h want 1 abcd", fwd_hit1, fwd_data);
    end
    n_checks++;
    if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'd0) begin
      n_fail++;
      $display("FAIL fwd_hit2: got hit=%b data=%h want 0 0", fwd_hit2, fwd_data2);
    end
    fwd_src2 = 5'd7;
    #1;
    n_checks++;
    if (fwd_hit2 !== 1'b1 || fwd_data2 !== 32'hABCD) begin
      n_fail++;
      $display("FAIL fwd_hit2_on: got hit=%b data=%h want 1 abcd", fwd_hit2, fwd_data2);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (fwd_hit1 !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_clear: got %b want 0", fwd_hit1);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
`ifdef REGFILE_WB_FWD_EN
    fwd_src1 = 5'd0;
    fwd_src2 = 5'd0;
`endif
    test_reset();
    test_a_only();
    test_starvation();
    test_x0();
    test_hold();
    test_same_dest();
    test_reset_mid();
`ifdef REGFILE_WB_FWD_EN
    test_fwd();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources.
- Source A is the in-order pipeline writeback stage; source B is the long-latency unit (mul/div, misaligned load sequencer).
- Arbitrates with A-priority and a bounded-wait guarantee for B, registers the winning write, and drives the register file's write-enable, destination and data.
- Sits between the MEM/WB boundary and the register file; a_ready low stalls the pipeline.

Parameters:
- N, 32, data width (matches register file width).
- MAX_WAIT, 4, cycles B may be refused while valid before it is forced to win (1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- a_valid  input  1  source A has a write pending.
- a_dest  input  5  source A destination register.
- a_data  input  N  source A write data.
- a_ready  output  1  source A write accepted this cycle.
- b_valid  input  1  source B has a write pending.
- b_dest  input  5  source B destination register.
- b_data  input  N  source B write data.
- b_ready  output  1  source B write accepted this cycle.
- hold  input  1  blocks all grants (flush/debug halt).
- RegWrite  output  1  register-file write enable (registered).
- wr_dest  output  5  register-file destination (registered).
- wr_data  output  N  register-file data (registered).

Behaviour:
- Reset (rst=0, asynchronous): RegWrite=0, wr_dest=0, wr_data=0, wait_cnt=0. a_ready/b_ready are 0 while rst=0.
- Handshake: a transfer occurs when valid and ready are both 1 at a rising edge.
  - ready is combinational from valid, hold and wait_cnt.
  - ready never depends on ready.
  - Sources hold dest/data stable while valid and not ready.
- Grant rule, evaluated each cycle:
  - hold=1: no grant.
  - else b_valid and wait_cnt==MAX_WAIT: grant B.
  - else a_valid: grant A.
  - else b_valid: grant B.
  - else: none.
  - At most one ready is high.
- wait_cnt:
  - Increments when b_valid=1 and B is not granted, including hold cycles.
  - Saturates at MAX_WAIT.
  - Clears to 0 on a B grant or when b_valid=0.
- Output stage, one-cycle latency:
  - On the edge after a grant: RegWrite=1, wr_dest/wr_data = granted source's values.
  - With no grant: RegWrite=0, wr_dest/wr_data hold their previous values.
- Destination x0: the grant and handshake complete normally, but RegWrite stays 0 for that cycle. x0 writes are consumed, never issued.
- Throughput: one write per cycle sustained. Back-to-back grants to the same or different sources are allowed.
- Simultaneous A and B to the same dest with no forced B: A wins this cycle; B is written next cycle or later, so B's value is the final value.
- hold asserted while RegWrite=1 from the previous grant: that registered write still completes; only new grants are blocked.
- Reset mid-operation clears any registered write; it is not issued.

Optional Feature:
- Macro: REGFILE_WB_FWD_EN.
- When defined, adds ports:
  - fwd_src1 input 5, fwd_src2 input 5.
  - fwd_hit1 output 1, fwd_hit2 output 1, fwd_data output N (serves src1) and fwd_data2 output N.
- fwd_hitK = RegWrite && wr_dest!=0 && wr_dest==fwd_srcK, combinational.
- fwd_data/fwd_data2 = wr_data when the corresponding hit is 1, else 0.
- fwd_hit1/fwd_hit2 reset to 0.
- Purpose: gives decode the in-flight write before the register-file write edge.
- When not defined: the ports do not exist; no comparator logic.

Test Plan:
- Reset: hold rst=0 with a_valid=1, b_valid=1 -> a_ready=0, b_ready=0, RegWrite=0, wr_dest=0, wr_data=0; release -> A granted first cycle.
- A only: a_valid=1, a_dest=5, a_data=0x1234 for 1 cycle -> a_ready=1 same cycle; next cycle RegWrite=1, wr_dest=5, wr_data=0x1234; cycle after, RegWrite=0.
- Starvation bound: a_valid=1 and b_valid=1 continuously, MAX_WAIT=4 -> A granted 4 cycles, B granted on cycle 5, wait_cnt=0, A granted again on cycle 6; pattern repeats.
- x0 drop: b_valid=1, b_dest=0, b_data=0xFFFF_FFFF, a_valid=0 -> b_ready=1; next cycle RegWrite=0.
- hold: hold=1 for 3 cycles with both valid -> no ready, wait_cnt reaches 3; hold=0 with MAX_WAIT=3 -> B granted first.
- Fwd (REGFILE_WB_FWD_EN): grant A dest=7 data=0xABCD; next cycle fwd_src1=7 -> fwd_hit1=1, fwd_data=0xABCD; fwd_src2=0 -> fwd_hit2=0.
